// File: rtl/vrf_access_ctrl.sv
// Element sequencer for the vector register file: reads vs1/vs2 element pairs,
// hands them to the execution lane, and writes the lane results back to vd.
module vrf_access_ctrl #(
  parameter int NUM_VREGS = 32,
  parameter int ELEMS     = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8
) (
  input  logic                         clk,
  input  logic                         nrst,
  // operation request from the issue stage
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_VREGS)-1:0] req_vs1,
  input  logic [$clog2(NUM_VREGS)-1:0] req_vs2,
  input  logic [$clog2(NUM_VREGS)-1:0] req_vd,
  input  logic [$clog2(ELEMS):0]       req_vl,
  // register file RAM
  output logic                         ram_re,
  output logic [ADDR_W-1:0]            ram_raddr1,
  output logic [ADDR_W-1:0]            ram_raddr2,
  input  logic [DATA_W-1:0]            ram_rdataA,
  input  logic [DATA_W-1:0]            ram_rdataB,
  output logic                         ram_we,
  output logic [ADDR_W-1:0]            ram_waddr,
  output logic [DATA_W-1:0]            ram_wdata,
  // execution lane
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [DATA_W-1:0]            op_a,
  output logic [DATA_W-1:0]            op_b,
  input  logic                         res_valid,
  output logic                         res_ready,
  input  logic [DATA_W-1:0]            res_data,
  output logic                         done
);

  localparam int VREG_W = $clog2(NUM_VREGS);
  localparam int ELEM_W = $clog2(ELEMS);
  localparam int CNT_W  = ELEM_W + 1;
  localparam logic [CNT_W-1:0] VL_MAX = CNT_W'(ELEMS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_OP,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [VREG_W-1:0]  vs1_q, vs1_d;
  logic [VREG_W-1:0]  vs2_q, vs2_d;
  logic [VREG_W-1:0]  vd_q, vd_d;
  logic [CNT_W-1:0]   vl_q, vl_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]   op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   req_vl_clamped;
  logic               res_fire;

  assign req_vl_clamped = (req_vl > VL_MAX) ? VL_MAX : req_vl;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vd_d      = vd_q;
    vl_d      = vl_q;
    rd_cnt_d  = rd_cnt_q;
    op_cnt_d  = op_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    done_d    = 1'b0;
    req_ready = 1'b0;
    ram_re    = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b0;
    res_fire  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          vs1_d    = req_vs1;
          vs2_d    = req_vs2;
          vd_d     = req_vd;
          vl_d     = req_vl_clamped;
          rd_cnt_d = '0;
          op_cnt_d = '0;
          wr_cnt_d = '0;
          if (req_vl_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        ram_re   = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        state_d  = S_OP;
      end

      S_OP: begin
        op_valid = 1'b1;
        // The next read is issued only on a handshake, so the registered RAM
        // output keeps the current pair stable while the lane stalls.
        if (op_ready) begin
          op_cnt_d = op_cnt_q + 1'b1;
          if (rd_cnt_q < vl_q) begin
            ram_re   = 1'b1;
            rd_cnt_d = rd_cnt_q + 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A result is only taken once its operands have been handed to the lane.
    if (state_q == S_OP || state_q == S_DRAIN) begin
      res_ready = (wr_cnt_q < op_cnt_q);
    end
    res_fire = res_valid & res_ready;
    if (res_fire) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    // The last result always lands in DRAIN; leaving on the accepting cycle
    // puts done and req_ready in the very next cycle.
    if (state_q == S_DRAIN && wr_cnt_d == vl_q) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      vl_q     <= '0;
      rd_cnt_q <= '0;
      op_cnt_q <= '0;
      wr_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      vd_q     <= vd_d;
      vl_q     <= vl_d;
      rd_cnt_q <= rd_cnt_d;
      op_cnt_q <= op_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      done_q   <= done_d;
    end
  end

  assign ram_raddr1 = {vs1_q, rd_cnt_q[ELEM_W-1:0]};
  assign ram_raddr2 = {vs2_q, rd_cnt_q[ELEM_W-1:0]};
  assign ram_we     = res_fire;
  assign ram_waddr  = {vd_q, wr_cnt_q[ELEM_W-1:0]};
  assign ram_wdata  = res_data;
  assign op_a       = ram_rdataA;
  assign op_b       = ram_rdataB;
  assign done       = done_q;

endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Bench for vrf_access_ctrl: behavioural RAM and lane, randomized handshakes,
// and a whole-operation reference model of the register file contents.
module tb_vrf_access_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        req_valid, req_ready;
  logic [4:0]  req_vs1, req_vs2, req_vd;
  logic [3:0]  req_vl;
  logic        ram_re, ram_we;
  logic [7:0]  ram_raddr1, ram_raddr2, ram_waddr;
  logic [31:0] ram_rdataA, ram_rdataB, ram_wdata;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        done;

  vrf_access_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_vs1    (req_vs1),
    .req_vs2    (req_vs2),
    .req_vd     (req_vd),
    .req_vl     (req_vl),
    .ram_re     (ram_re),
    .ram_raddr1 (ram_raddr1),
    .ram_raddr2 (ram_raddr2),
    .ram_rdataA (ram_rdataA),
    .ram_rdataB (ram_rdataB),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- behavioural RAM ----------------
  logic [31:0] mem     [0:255];
  logic [31:0] mem_exp [0:255];
  logic        init_req = 1'b0;
  logic [31:0] init_seed = '0;
  logic [31:0] cur_seed = '0;

  function automatic logic [31:0] init_val(int a, logic [31:0] seed);
    return (seed == 0) ? 32'(a) : ((32'(a) * 32'h9E37_79B1) ^ seed);
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int a = 0; a < 256; a++) mem[a] <= init_val(a, init_seed);
    end else begin
      if (ram_re) begin
        ram_rdataA <= mem[ram_raddr1];
        ram_rdataB <= mem[ram_raddr2];
      end
      if (ram_we) mem[ram_waddr] <= ram_wdata;
    end
  end

  // ---------------- lane model and observers ----------------
  typedef struct {
    logic [31:0] data;
    int          avail;
  } res_t;

  res_t        res_q[$];
  logic [63:0] ops_q[$], exp_ops[$];
  logic [39:0] wr_q[$], exp_wr[$];
  int          acc_cyc[$], done_cyc[$];
  int          n_re, stall_bad, stall_chk, early_bad, stall_cnt;
  int          rdy_mode, stall_n, rdy_pct, res_pct, lat_max, lane_mode, hold_cnt;
  logic        holding, prev_stall;
  logic [63:0] prev_ab;

  function automatic logic [31:0] lane_fn(logic [31:0] a, logic [31:0] b, int mode);
    case (mode)
      0:       return a + b;
      1:       return a + 32'd1;
      default: return (a ^ b) + 32'h1234_5678;
    endcase
  endfunction

  initial begin
    op_ready   = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    prev_stall = 1'b0;
    prev_ab    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (hold_cnt > 0) begin
        holding   = 1'b1;
        hold_cnt--;
        op_ready  = 1'b0;
        res_valid = 1'b1;
        res_data  = 32'hBAD0_0BAD;
      end else begin
        holding = 1'b0;
        case (rdy_mode)
          0:       op_ready = 1'b1;
          1:       op_ready = (stall_cnt >= stall_n);
          default: op_ready = ($urandom_range(0, 99) < rdy_pct);
        endcase
        res_valid = (res_q.size() > 0) && (cyc >= res_q[0].avail) &&
                    ($urandom_range(0, 99) < res_pct);
        res_data  = res_valid ? res_q[0].data : $urandom;
      end
      #1;
      if (!nrst) begin
        res_q.delete();
        stall_cnt  = 0;
        prev_stall = 1'b0;
        continue;
      end
      if (holding && (res_ready || ram_we)) early_bad++;
      if (req_valid && req_ready) acc_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (ram_re) n_re++;
      if (ram_we) wr_q.push_back({ram_waddr, ram_wdata});
      if (!holding && res_valid && res_ready && res_q.size() > 0) void'(res_q.pop_front());
      if (prev_stall && op_valid) begin
        stall_chk++;
        if ({op_a, op_b} !== prev_ab) stall_bad++;
      end
      prev_stall = op_valid && !op_ready;
      prev_ab    = {op_a, op_b};
      if (op_valid && op_ready) begin
        ops_q.push_back({op_a, op_b});
        res_q.push_back('{lane_fn(op_a, op_b, lane_mode),
                          cyc + ((lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max)))});
        stall_cnt = 0;
      end else if (op_valid) begin
        stall_cnt++;
      end
    end
  end

  // ---------------- reference model and utilities ----------------
  function automatic int clampv(int v);
    return (v > 8) ? 8 : v;
  endfunction

  // Whole-operation semantics: element i of vd = f(vs1[i], vs2[i]), applied in order.
  task automatic model_op(input int s1, input int s2, input int d, input int vl_raw);
    int vl;
    logic [31:0] a, b, r;
    vl = clampv(vl_raw);
    for (int i = 0; i < vl; i++) begin
      a = mem_exp[s1 * 8 + i];
      b = mem_exp[s2 * 8 + i];
      r = lane_fn(a, b, lane_mode);
      exp_ops.push_back({a, b});
      exp_wr.push_back({8'(d * 8 + i), r});
      mem_exp[d * 8 + i] = r;
    end
  endtask

  task automatic preload(input logic [31:0] seed);
    @(negedge clk);
    init_seed = seed;
    cur_seed  = seed;
    init_req  = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    for (int a = 0; a < 256; a++) mem_exp[a] = init_val(a, seed);
  endtask

  task automatic clear_obs();
    ops_q.delete();   exp_ops.delete();
    wr_q.delete();    exp_wr.delete();
    acc_cyc.delete(); done_cyc.delete();
    n_re = 0; stall_bad = 0; stall_chk = 0; early_bad = 0; stall_cnt = 0;
  endtask

  task automatic start_op(input int s1, input int s2, input int d, input int vl);
    int n0;
    @(negedge clk);
    req_vs1   = 5'(s1);
    req_vs2   = 5'(s2);
    req_vd    = 5'(d);
    req_vl    = 4'(vl);
    req_valid = 1'b1;
    n0 = acc_cyc.size();
    for (int k = 0; k < 400; k++) begin
      #2;
      if (acc_cyc.size() > n0) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      #2;
      if (done_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic int ops_diff();
    if (ops_q.size() != exp_ops.size()) return -2;
    foreach (ops_q[i]) if (ops_q[i] !== exp_ops[i]) return i;
    return -1;
  endfunction

  function automatic int wr_diff();
    if (wr_q.size() != exp_wr.size()) return -2;
    foreach (wr_q[i]) if (wr_q[i] !== exp_wr[i]) return i;
    return -1;
  endfunction

  function automatic int mem_diff();
    for (int a = 0; a < 256; a++) if (mem[a] !== mem_exp[a]) return a;
    return -1;
  endfunction

  function automatic int latency(int k);
    if (done_cyc.size() <= k || acc_cyc.size() <= k) return -1;
    return done_cyc[k] - acc_cyc[k];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rdy_mode = 0;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b, expected 1", req_ready);
    end
    n_checks++;
    if ({ram_re, ram_we, op_valid, res_ready, done} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl re/we/opv/resr/done: got %b, expected 00000",
                         {ram_re, ram_we, op_valid, res_ready, done});
    end
    n_checks++;
    if ({ram_raddr1, ram_raddr2, ram_waddr} !== 24'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h, expected 000000", {ram_raddr1, ram_raddr2, ram_waddr});
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({req_ready, op_valid, done} !== 3'b100) begin
      n_fail++; $display("FAIL idle_after_reset rdy/opv/done: got %b, expected 100", {req_ready, op_valid, done});
    end
  endtask

  task automatic test_full_vector();
    bit ok;
    int idx;
    preload(32'h0);
    rdy_mode = 0; lat_max = 1; res_pct = 100; lane_mode = 0;
    clear_obs();
    model_op(2, 3, 4, 8);
    start_op(2, 3, 4, 8);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: got no done, expected done"); end
    idx = ops_diff(); n_checks++;
    if (idx != -1) begin
      n_fail++; $display("FAIL full_ops: bad index %0d, got %0d pairs, expected %0d", idx, ops_q.size(), exp_ops.size());
    end
    idx = wr_diff(); n_checks++;
    if (idx != -1) begin
      n_fail++; $display("FAIL full_writes: bad index %0d, got %0d writes, expected %0d", idx, wr_q.size(), exp_wr.size());
    end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin
      n_fail++; $display("FAIL full_mem[%0d]: got %0d, expected %0d", idx, mem[idx], mem_exp[idx]);
    end
    n_checks++;
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL full_done_count: got %0d, expected 1", done_cyc.size()); end
    n_checks++;
    if (latency(0) != 11) begin n_fail++; $display("FAIL full_done_latency: got %0d, expected 11", latency(0)); end
    n_checks++;
    if (n_re != 8) begin n_fail++; $display("FAIL full_re_count: got %0d, expected 8", n_re); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int idx;
    preload($urandom | 32'h1);
    rdy_mode = 1; stall_n = 2; lat_max = 1; res_pct = 100; lane_mode = 2;
    clear_obs();
    model_op(7, 1, 10, 3);
    start_op(7, 1, 10, 3);
    wait_done(1, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_timeout: got no done, expected done"); end
    n_checks++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL bp_operand_stable: got %0d changes, expected 0", stall_bad); end
    n_checks++;
    if (stall_chk != 6) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d, expected 6", stall_chk); end
    n_checks++;
    if (n_re != 3) begin n_fail++; $display("FAIL bp_re_count: got %0d, expected 3", n_re); end
    idx = ops_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL bp_ops: bad index %0d, got %0d, expected %0d", idx, ops_q.size(), exp_ops.size()); end
    idx = wr_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL bp_writes: bad index %0d, got %0d, expected %0d", idx, wr_q.size(), exp_wr.size()); end
    rdy_mode = 0;
  endtask

  task automatic test_zero_clamp();
    bit ok;
    int idx;
    rdy_mode = 0; lat_max = 1; res_pct = 100; lane_mode = 0;
    clear_obs();
    start_op(1, 2, 3, 0);
    wait_done(1, 50, ok);
    n_checks++;
    if (!ok || latency(0) != 1) begin n_fail++; $display("FAIL zero_done_latency: got %0d, expected 1", latency(0)); end
    n_checks++;
    if (n_re != 0 || wr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_ram_access: got %0d reads %0d writes, expected 0 0", n_re, wr_q.size());
    end
    n_checks++;
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d, expected 1", done_cyc.size()); end
    clear_obs();
    model_op(11, 12, 13, 15);
    start_op(11, 12, 13, 15);
    wait_done(1, 200, ok);
    idx = ops_diff(); n_checks++;
    if (!ok || idx != -1) begin n_fail++; $display("FAIL clamp_ops: bad index %0d, got %0d, expected %0d", idx, ops_q.size(), exp_ops.size()); end
    n_checks++;
    if (n_re != 8) begin n_fail++; $display("FAIL clamp_re_count: got %0d, expected 8", n_re); end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL clamp_mem[%0d]: got %h, expected %h", idx, mem[idx], mem_exp[idx]); end
  endtask

  task automatic test_in_place();
    bit ok;
    int idx;
    preload($urandom | 32'h1);
    rdy_mode = 2; rdy_pct = 60; res_pct = 70; lat_max = 2; lane_mode = 1;
    clear_obs();
    model_op(5, 6, 5, 8);
    start_op(5, 6, 5, 8);
    wait_done(1, 400, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL inplace_timeout: got no done, expected done"); end
    idx = ops_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL inplace_ops: bad index %0d, got %0d, expected %0d", idx, ops_q.size(), exp_ops.size()); end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL inplace_mem[%0d]: got %h, expected %h", idx, mem[idx], mem_exp[idx]); end
    rdy_mode = 0; res_pct = 100; lat_max = 1;
  endtask

  task automatic test_early_result();
    bit ok;
    int idx;
    rdy_mode = 0; lat_max = 1; res_pct = 100; lane_mode = 0;
    clear_obs();
    model_op(8, 9, 20, 4);
    #3;
    hold_cnt = 6;
    start_op(8, 9, 20, 4);
    wait_done(1, 200, ok);
    n_checks++;
    if (early_bad != 0) begin n_fail++; $display("FAIL early_res_blocked: got %0d accepting cycles, expected 0", early_bad); end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL early_timeout: got no done, expected done"); end
    idx = wr_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL early_writes: bad index %0d, got %0d, expected %0d", idx, wr_q.size(), exp_wr.size()); end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL early_mem[%0d]: got %h, expected %h", idx, mem[idx], mem_exp[idx]); end
  endtask

  task automatic test_reset_mid_op();
    int idx;
    bit seen;
    preload($urandom | 32'h1);
    rdy_mode = 0; lat_max = 1; res_pct = 100; lane_mode = 0;
    clear_obs();
    model_op(14, 15, 16, 8);
    for (int i = 4; i < 8; i++) mem_exp[16 * 8 + i] = init_val(16 * 8 + i, cur_seed);
    start_op(14, 15, 16, 8);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (wr_q.size() >= 4) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL midrst_wait: got %0d writes, expected 4", wr_q.size()); end
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, ram_re, ram_we, op_valid, res_ready, done} !== 6'b100000) begin
      n_fail++; $display("FAIL midrst_outputs rdy/re/we/opv/resr/done: got %b, expected 100000",
                         {req_ready, ram_re, ram_we, op_valid, res_ready, done});
    end
    n_checks++;
    if ({ram_raddr1, ram_raddr2, ram_waddr} !== 24'h0) begin
      n_fail++; $display("FAIL midrst_addr: got %h, expected 000000", {ram_raddr1, ram_raddr2, ram_waddr});
    end
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (done_cyc.size() != 0) begin n_fail++; $display("FAIL midrst_done: got %0d pulses, expected 0", done_cyc.size()); end
    n_checks++;
    if (wr_q.size() != 4) begin n_fail++; $display("FAIL midrst_write_count: got %0d, expected 4", wr_q.size()); end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL midrst_mem[%0d]: got %h, expected %h", idx, mem[idx], mem_exp[idx]); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int idx;
    preload($urandom | 32'h1);
    rdy_mode = 0; lat_max = 1; res_pct = 100; lane_mode = 0;
    clear_obs();
    model_op(1, 2, 3, 5);
    model_op(3, 4, 6, 7);
    start_op(1, 2, 3, 5);
    start_op(3, 4, 6, 7);
    wait_done(2, 300, ok);
    n_checks++;
    if (!ok || done_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d, expected 2", done_cyc.size()); end
    n_checks++;
    if (acc_cyc.size() < 2 || done_cyc.size() < 1 || acc_cyc[1] != done_cyc[0]) begin
      n_fail++; $display("FAIL b2b_accept_in_done_cycle: got accept count %0d, expected second accept in first done cycle",
                         acc_cyc.size());
    end
    idx = ops_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL b2b_ops: bad index %0d, got %0d, expected %0d", idx, ops_q.size(), exp_ops.size()); end
    idx = wr_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL b2b_writes: bad index %0d, got %0d, expected %0d", idx, wr_q.size(), exp_wr.size()); end
    idx = mem_diff(); n_checks++;
    if (idx != -1) begin n_fail++; $display("FAIL b2b_mem[%0d]: got %h, expected %h", idx, mem[idx], mem_exp[idx]); end
  endtask

  task automatic test_random();
    bit ok;
    int idx, s1, s2, d, vl;
    preload($urandom | 32'h1);
    for (int it = 0; it < 10; it++) begin
      rdy_mode  = 2;
      rdy_pct   = $urandom_range(30, 100);
      res_pct   = $urandom_range(30, 100);
      lat_max   = $urandom_range(1, 3);
      lane_mode = $urandom_range(0, 2);
      s1 = $urandom_range(0, 31);
      s2 = $urandom_range(0, 31);
      d  = $urandom_range(0, 31);
      vl = $urandom_range(0, 15);
      clear_obs();
      model_op(s1, s2, d, vl);
      start_op(s1, s2, d, vl);
      wait_done(1, 600, ok);
      n_checks++;
      if (!ok || done_cyc.size() != 1) begin
        n_fail++; $display("FAIL rand%0d_done: got %0d pulses, expected 1", it, done_cyc.size());
      end
      n_checks++;
      if (n_re != clampv(vl)) begin n_fail++; $display("FAIL rand%0d_re_count: got %0d, expected %0d", it, n_re, clampv(vl)); end
      idx = ops_diff(); n_checks++;
      if (idx != -1) begin
        n_fail++; $display("FAIL rand%0d_ops: bad index %0d, got %0d, expected %0d", it, idx, ops_q.size(), exp_ops.size());
      end
      idx = wr_diff(); n_checks++;
      if (idx != -1) begin
        n_fail++; $display("FAIL rand%0d_writes: bad index %0d, got %0d, expected %0d", it, idx, wr_q.size(), exp_wr.size());
      end
      idx = mem_diff(); n_checks++;
      if (idx != -1) begin n_fail++; $display("FAIL rand%0d_mem[%0d]: got %h, expected %h", it, idx, mem[idx], mem_exp[idx]); end
      n_checks++;
      if (stall_bad != 0) begin n_fail++; $display("FAIL rand%0d_operand_stable: got %0d changes, expected 0", it, stall_bad); end
    end
  endtask

  initial begin
    nrst      = 1'b0;
    req_valid = 1'b0;
    req_vs1   = '0;
    req_vs2   = '0;
    req_vd    = '0;
    req_vl    = '0;
    rdy_mode  = 0; stall_n = 0; rdy_pct = 100; res_pct = 100;
    lat_max   = 1; lane_mode = 0; hold_cnt = 0;
    n_re = 0; stall_bad = 0; stall_chk = 0; early_bad = 0; stall_cnt = 0;

    test_reset();
    test_full_vector();
    test_backpressure();
    test_zero_clamp();
    test_in_place();
    test_early_result();
    test_reset_mid_op();
    test_back_to_back();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_access_ctrl.md
# vrf_access_ctrl

Element sequencer that drives the vector register file RAM, which has two registered read ports and one write port. It accepts one vector operation (vs1, vs2, vd, vl), reads the source elements pairwise, and hands them to the execution lane over a valid/ready handshake. It then writes the lane's results back to vd element by element and pulses `done` when the last write is accepted. It sits between the vector issue stage and the 256 x 32 register file: 32 vector registers of 8 elements each.

## Interface

**Parameters**
- `NUM_VREGS`, 32, number of vector registers
- `ELEMS`, 8, elements per vector register (power of two)
- `DATA_W`, 32, element width
- `ADDR_W`, 8, RAM address width; equals log2(NUM_VREGS) + log2(ELEMS)

**Ports**
- `clk`  in  1  single clock, rising edge
- `nrst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  operation request
- `req_ready`  out  1  high only in IDLE
- `req_vs1`, `req_vs2`, `req_vd`  in  5 each  source and destination register numbers
- `req_vl`  in  4  element count 0..8; values above 8 are clamped to 8
- `ram_re`  out  1  RAM read enable
- `ram_raddr1`, `ram_raddr2`  out  ADDR_W each  read addresses
- `ram_rdataA`, `ram_rdataB`  in  DATA_W each  RAM read data; registered, valid 1 cycle after `ram_re`, held while `ram_re` is low
- `ram_we`  out  1  RAM write enable
- `ram_waddr`  out  ADDR_W  write address
- `ram_wdata`  out  DATA_W  write data
- `op_valid`  out  1  operand pair valid
- `op_ready`  in  1  lane accepts the operand pair
- `op_a`, `op_b`  out  DATA_W each  operands; wired directly from `ram_rdataA` / `ram_rdataB`
- `res_valid`  in  1  lane result valid
- `res_ready`  out  1  result accepted
- `res_data`  in  DATA_W  lane result
- `done`  out  1  one-cycle pulse at operation completion

## Operation

- **Address map:** element i of register v is at address {v, i[2:0]}.
- **Request capture:** in IDLE, `req_valid` latches vs1, vs2, vd and clamped vl, and clears counters `rd_cnt`, `op_cnt`, `wr_cnt` (4 bits each).
- **States:** IDLE, RD, OP, DRAIN.
- **IDLE:**
  - `req_valid` with vl > 0 -> RD.
  - `req_valid` with vl = 0 -> stay in IDLE, `done` pulses next cycle, no RAM access.
- **RD:** drive `ram_re`=1 with addresses for element `rd_cnt`, increment `rd_cnt`, go to OP.
- **OP:** `op_valid`=1.
  - On `op_valid` & `op_ready`, increment `op_cnt`.
  - If `rd_cnt` < vl, drive `ram_re`=1 in the same cycle with the next element's addresses, increment `rd_cnt`, stay in OP. This `ram_re` is combinational from `op_ready`.
  - Otherwise go to DRAIN.
  - Without a handshake, `ram_re`=0 and `op_a`/`op_b` stay stable because the RAM holds its output.
- **DRAIN:** `op_valid`=0; wait for results.
- **Result path (OP and DRAIN):**
  - `res_ready` = (`wr_cnt` < `op_cnt`); a result is never accepted before its operands have been handed off.
  - `ram_we` = `res_valid` & `res_ready`, `ram_waddr` = {vd, `wr_cnt`}, `ram_wdata` = `res_data`. All combinational.
  - `wr_cnt` increments on each accepted result.
- **Completion:** in DRAIN, when `wr_cnt` == vl, go to IDLE and pulse `done`=1 for exactly one cycle.
- **Overlap (vd equal to vs1/vs2):** element i is always read before result i is written, and different elements map to different addresses. No hazard logic is required.
- **Same-cycle read and write** to different addresses is legal and expected in OP.
- **Reset mid-operation:** the operation is abandoned with no `done` and no further RAM writes.

## Timing

- **Reset values:** state=IDLE, all counters 0, `done`=0. Consequently `req_ready`=1, `ram_re`=0, `ram_we`=0, `op_valid`=0, `res_ready`=0. `ram_raddr1`/`ram_raddr2`/`ram_waddr` derive from the captured registers, which reset to 0, so all addresses are 0. `op_a`/`op_b` follow the RAM outputs.
- **First operand:** request accepted in cycle 0 -> `ram_re` in cycle 1 (RD) -> `op_valid` in cycle 2.
- **Throughput:** with `op_ready` held high, 1 element per cycle; vl elements present on `op_valid` during cycles 2..vl+1.
- **`done`:** asserted in the cycle after the final result is accepted; `req_ready` is high in that same cycle.
- **Back-to-back:** a new request can be accepted in the `done` cycle.

## Test plan

- **Full vector:** vs1=2, vs2=3, vd=4, vl=8, RAM preloaded so mem[a]=a. `op_ready`=1, lane returns a+b one cycle later. Required: op pairs (16,24)..(23,31); mem[32..39] = 40,42,..,54; `done` exactly once; minimum `done` latency.
- **Lane backpressure:** vl=3, `op_ready` low for 2 cycles per element. Required: `op_a`/`op_b` stable while stalled; exactly 3 `ram_re` pulses; 3 writes in order.
- **Zero length, then clamp:** vl=0 -> `done` 1 cycle after acceptance, no `ram_re`/`ram_we`. Then vl=15 -> exactly 8 elements processed.
- **In-place operation:** vd=vs1=5, vl=8, result = a+1. Required: mem[40..47] each increment by 1, with no element read after its write.
- **Early result blocked:** drive `res_valid` before the first op handshake. Required: `res_ready`=0 and no write until `op_cnt` > `wr_cnt`.
- **Reset mid-operation:** assert `nrst` low after 4 writes of a vl=8 operation. Required: all outputs at reset values immediately, `done` never asserted, mem[vd*8+4..7] untouched.
